sram_1r1w: RTL and testbench
============================

Name: sram_1r1w

Overview:
- Parametrised successor of the team's single-port SRAM macro model.
- Separate read and write ports, usable in the same cycle.
- Configurable width, depth and read latency (1 or 2 cycles).
- Write-first bypass on same-address collisions; optional post-reset clear sequencer.
- Sits between the core pipeline (IF/MEM stages) and on-chip storage. Also serves as the register-file/scratchpad backing store.

Parameters:
- DW, 32, data width in bits
- AW, 8, address width; DEPTH = 2**AW words
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- CLR_ON_RST, 1, 1 = run clear sequence after reset; 0 = contents undefined after reset
- INIT_VAL, 0, DW-bit value written to every word by the clear sequence

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rcen  in  1  read chip enable, active-low
- ra  in  AW  read address
- rq  out  DW  read data
- rvalid  out  1  rq carries data for a read accepted RD_LAT cycles earlier
- wcen  in  1  write chip enable, active-low
- wa  in  AW  write address
- wd  in  DW  write data
- bwen  in  DW  bit write mask; 1 = write that bit, 0 = keep stored bit
- init_busy  out  1  clear sequence in progress; all requests ignored

Behaviour:
- Reset (rst_n=0, async):
  - rq=0, rvalid=0, RD_LAT=2 pipe stage=0.
  - init_busy=1 if CLR_ON_RST else 0; clear counter=0; FSM -> INIT (CLR_ON_RST=1) or READY.
  - Memory array is not reset.
- FSM states INIT, READY:
  - INIT: each cycle mem[cnt] <= INIT_VAL, cnt++. After writing DEPTH-1, go to READY next edge. init_busy=0 from that edge. INIT takes exactly DEPTH cycles.
  - INIT: rcen/wcen ignored. No writes land and rvalid stays 0.
  - Reset asserted mid-INIT restarts the sequence from address 0.
  - READY: stays until reset.
- Write (READY, wcen=0): at the rising edge, each bit j with bwen[j]=1 takes wd[j]; bits with bwen[j]=0 hold. bwen=0 is a legal no-op.
- Read (READY, rcen=0), sampled at edge N:
  - RD_LAT=1: rq and rvalid=1 update at edge N.
  - RD_LAT=2: data is registered at edge N and presented at edge N+1.
  - rvalid is a single-cycle pulse per accepted read. Back-to-back reads give a continuous rvalid, one result per cycle, in order.
- No read accepted: rq holds its last value; rvalid=0.
- Collision (rcen=0, wcen=0, ra==wa, same edge): write-first. Returned word = (wd & bwen) | (old & ~bwen), computed bitwise.
- Write at edge N, read of the same address sampled at edge N+1: sees the new data with no special logic.
- Simultaneous read and write to different addresses: fully independent.
- Address width: addresses are always in range; no wrap or bounds logic is needed.

Decomposition:
- Package sram_pkg:
  - typedef enum {INIT, READY} sram_state_t
  - localparam RD_LAT_MAX = 2
  - function merge_bits(old, new, mask), used by both the write path and the bypass.
- One sub-module, sram_rd_pipe: the optional second read stage (data + valid), instantiated when RD_LAT=2. It has the same clk/rst_n.
- Parameter check: an elaboration-time assertion rejects RD_LAT outside {1,2}.

Test Plan:
- Reset + clear (AW=4, INIT_VAL=32'hDEAD_BEEF): release rst_n.
  - Required: init_busy high for exactly 16 cycles.
  - Required: reading all 16 addresses afterwards returns 32'hDEAD_BEEF, rvalid one cycle per read.
  - Required: a write issued during init_busy is dropped.
- Bit-masked write:
  - Stimulus: write 32'hFFFF_FFFF to addr 3, then wd=32'h0000_0000 with bwen=32'h0000_FF00 to addr 3, then read addr 3.
  - Required: rq=32'hFFFF_00FF.
- Collision bypass:
  - Stimulus: mem[5]=32'h1234_5678; same edge write wd=32'hAAAA_AAAA with bwen=32'hFFFF_0000 and read addr 5.
  - Required: rq=32'hAAAA_5678. A later read also returns 32'hAAAA_5678.
- Latency (RD_LAT=2):
  - Stimulus: back-to-back reads of addrs 1,2,3 holding 32'h11,32'h22,32'h33.
  - Required: rvalid high on edges N+1..N+3 with rq=32'h11,32'h22,32'h33.
  - Required: rq holds 32'h33 afterwards with rvalid=0.
- Reset mid-init (AW=4):
  - Stimulus: assert rst_n=0 at init cycle 7 for 1 cycle.
  - Required: rq=0 and rvalid=0 immediately (async). init_busy stays high 16 full cycles after release.
- No-op and hold:
  - Stimulus: wcen=0 with bwen=0 to addr 9 holding 32'h0F0F_0F0F, rcen=1.
  - Required: contents unchanged, rq unchanged, rvalid=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1R1W SRAM model.
package sram_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } sram_state_t;

    localparam int RD_LAT_MAX = 2;

    // Widest data word the bitwise merge helper supports; callers zero-extend.
    localparam int MERGE_W = 1024;

    // Bitwise masked update: mask bit 1 takes the new bit, 0 keeps the old bit.
    function automatic logic [MERGE_W-1:0] merge_bits(
        input logic [MERGE_W-1:0] old_v,
        input logic [MERGE_W-1:0] new_v,
        input logic [MERGE_W-1:0] mask
    );
        return (new_v & mask) | (old_v & ~mask);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Optional second read stage: registers data/valid once more for RD_LAT=2.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    output logic [DW-1:0] out_data
);

    logic          vld_q, vld_d;
    logic [DW-1:0] data_q, data_d;

    // Capture data only for a real read so the output holds between reads.
    always_comb begin
        vld_d  = in_vld;
        data_d = in_vld ? in_data : data_q;
    end

    // Stage registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_data = data_q;

endmodule

// File: rtl/sram_1r1w.sv
// Parametrised 1-read/1-write SRAM with write-first bypass and clear sequencer.
module sram_1r1w
    import sram_pkg::*;
#(
    parameter int          DW         = 32,
    parameter int          AW         = 8,
    parameter int          RD_LAT     = 1,
    parameter bit          CLR_ON_RST = 1'b1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rcen,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rq,
    output logic          rvalid,
    input  logic          wcen,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [DW-1:0] bwen,
    output logic          init_busy
);

    localparam int DEPTH = 2 ** AW;

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("sram_1r1w: RD_LAT must be 1 or 2");
    end
    if (DW > MERGE_W) begin : g_bad_dw
        $error("sram_1r1w: DW exceeds merge helper width");
    end

    sram_state_t   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem [DEPTH];

    logic          ready, rd_acc, wr_acc;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata, merged, rword;

    logic [DW-1:0] s1_data_q, s1_data_d;
    logic          s1_vld_q, s1_vld_d;

    // Clear sequencer: walk every address once, then stay ready until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (&cnt_q) state_d = READY;
        end
    end

    // Sequencer state, restarted from address 0 by any reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_ON_RST ? INIT : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write port muxing and write-first read word selection.
    always_comb begin
        ready  = (state_q == READY);
        rd_acc = ready & ~rcen;
        wr_acc = ready & ~wcen;
        merged = DW'(merge_bits(MERGE_W'(mem[wa]), MERGE_W'(wd), MERGE_W'(bwen)));
        we     = wr_acc;
        waddr  = wa;
        wdata  = merged;
        if (!ready) begin
            we    = 1'b1;
            waddr = cnt_q;
            wdata = INIT_VAL;
        end
        rword = mem[ra];
        if (wr_acc && (ra == wa)) rword = merged;
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // First read stage; data holds when no read is accepted.
    always_comb begin
        s1_vld_d  = rd_acc;
        s1_data_d = rd_acc ? rword : s1_data_q;
    end

    // First read stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        sram_rd_pipe #(.DW(DW)) u_rd_pipe (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_vld   (s1_vld_q),
            .in_data  (s1_data_q),
            .out_vld  (rvalid),
            .out_data (rq)
        );
    end else begin : g_lat1
        assign rvalid = s1_vld_q;
        assign rq     = s1_data_q;
    end

    assign init_busy = (state_q == INIT);

endmodule

// File: tb/tb_sram_1r1w.sv
// Bench: RD_LAT=1 and RD_LAT=2 instances share stimulus, checked against an array model.
module tb_sram_1r1w;

    localparam logic [31:0] IV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rcen = 1'b1, wcen = 1'b1;
    logic [3:0]  ra = '0, wa = '0;
    logic [31:0] wd = '0, bwen = '0;
    logic [31:0] rq1, rq2;
    logic        rv1, rv2, busy1, busy2;

    int n_chk = 0, n_fail = 0;

    // Reference model state
    logic [31:0] m_mem [16];
    int          init_left;
    logic [31:0] e_q1, e_q2, p_d;
    logic        e_v1, e_v2, p_v;

    always #5 clk = ~clk;

    sram_1r1w #(.DW(32), .AW(4), .RD_LAT(1), .CLR_ON_RST(1'b1), .INIT_VAL(IV)) u1 (
        .clk(clk), .rst_n(rst_n), .rcen(rcen), .ra(ra), .rq(rq1), .rvalid(rv1),
        .wcen(wcen), .wa(wa), .wd(wd), .bwen(bwen), .init_busy(busy1));

    sram_1r1w #(.DW(32), .AW(4), .RD_LAT(2), .CLR_ON_RST(1'b1), .INIT_VAL(IV)) u2 (
        .clk(clk), .rst_n(rst_n), .rcen(rcen), .ra(ra), .rq(rq2), .rvalid(rv2),
        .wcen(wcen), .wa(wa), .wd(wd), .bwen(bwen), .init_busy(busy2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge: predict, advance, compare everything.
    task automatic step();
        logic        acc_r, acc_w;
        logic [31:0] nw, word;
        acc_r = (init_left == 0) && !rcen;
        acc_w = (init_left == 0) && !wcen;
        nw    = (wd & bwen) | (m_mem[wa] & ~bwen);
        word  = (acc_w && ra == wa) ? nw : m_mem[ra];
        @(posedge clk); #1;
        if (acc_w) m_mem[wa] = nw;
        if (init_left > 0) begin
            init_left--;
            if (init_left == 0) for (int i = 0; i < 16; i++) m_mem[i] = IV;
        end
        e_v1 = acc_r;
        if (acc_r) e_q1 = word;
        e_v2 = p_v;
        if (p_v) e_q2 = p_d;
        p_v = acc_r;
        p_d = word;
        chk("busy1", 32'(busy1), 32'(init_left > 0));
        chk("busy2", 32'(busy2), 32'(init_left > 0));
        chk("rvalid1", 32'(rv1), 32'(e_v1));
        chk("rq1", rq1, e_q1);
        chk("rvalid2", 32'(rv2), 32'(e_v2));
        chk("rq2", rq2, e_q2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rq1", rq1, 32'h0);
        chk("rst_rv1", 32'(rv1), 32'h0);
        chk("rst_rq2", rq2, 32'h0);
        chk("rst_rv2", 32'(rv2), 32'h0);
        chk("rst_busy", 32'(busy1 & busy2), 32'h1);
        init_left = 16;
        e_q1 = '0; e_q2 = '0; e_v1 = 1'b0; e_v2 = 1'b0; p_v = 1'b0; p_d = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic count_init(input string tag);
        int cnt;
        cnt = 0;
        while (busy1 && cnt < 40) begin
            step();
            cnt++;
        end
        chk(tag, cnt, 32'd16);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] m);
        wcen = 1'b0; wa = a; wd = d; bwen = m;
        step();
        wcen = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a);
        rcen = 1'b0; ra = a;
        step();
        rcen = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 'x;

        // Reset, with a write to addr 2 attempted throughout the clear.
        do_reset();
        wcen = 1'b0; wa = 4'd2; wd = 32'h5555_5555; bwen = '1;
        rcen = 1'b0; ra = 4'd2;
        count_init("init_cycles");
        wcen = 1'b1; rcen = 1'b1;

        // All addresses cleared, back-to-back reads.
        for (int a = 0; a < 16; a++) begin
            rcen = 1'b0; ra = 4'(a);
            step();
        end
        rcen = 1'b1;
        step(); step();
        chk("clear_word", rq2, IV);

        // Bit-masked write.
        wr(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wr(4'd3, 32'h0000_0000, 32'h0000_FF00);
        rd(4'd3);
        chk("mask_rq1", rq1, 32'hFFFF_00FF);
        step();
        chk("mask_rq2", rq2, 32'hFFFF_00FF);

        // Collision bypass.
        wr(4'd5, 32'h1234_5678, 32'hFFFF_FFFF);
        wcen = 1'b0; wa = 4'd5; wd = 32'hAAAA_AAAA; bwen = 32'hFFFF_0000;
        rcen = 1'b0; ra = 4'd5;
        step();
        wcen = 1'b1; rcen = 1'b1;
        chk("coll_rq1", rq1, 32'hAAAA_5678);
        step();
        rd(4'd5);
        chk("coll_later", rq1, 32'hAAAA_5678);
        step();

        // Latency: back-to-back reads of 1,2,3.
        wr(4'd1, 32'h11, '1);
        wr(4'd2, 32'h22, '1);
        wr(4'd3, 32'h33, '1);
        for (int a = 1; a <= 3; a++) begin
            rcen = 1'b0; ra = 4'(a);
            step();
        end
        rcen = 1'b1;
        step();
        chk("lat_last", rq2, 32'h33);
        step();
        chk("lat_hold_rq", rq2, 32'h33);
        chk("lat_hold_rv", 32'(rv2), 32'h0);

        // No-op write with bwen=0 and no read.
        wr(4'd9, 32'h0F0F_0F0F, '1);
        rd(4'd9);
        step();
        wcen = 1'b0; wa = 4'd9; wd = 32'hF0F0_F0F0; bwen = '0;
        step();
        wcen = 1'b1;
        chk("noop_rq", rq1, 32'h0F0F_0F0F);
        chk("noop_rv", 32'(rv1), 32'h0);
        rd(4'd9);
        chk("noop_mem", rq1, 32'h0F0F_0F0F);
        step();

        // Reset mid-init restarts the full clear.
        do_reset();
        for (int i = 0; i < 7; i++) step();
        do_reset();
        count_init("reinit_cycles");

        // Random traffic with frequent address collisions.
        for (int i = 0; i < 400; i++) begin
            rcen = 1'($urandom_range(0, 1));
            wcen = 1'($urandom_range(0, 1));
            ra   = 4'($urandom_range(0, 15));
            wa   = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            wd   = $urandom();
            bwen = ($urandom_range(0, 1) == 0) ? '1 : $urandom();
            step();
        end
        rcen = 1'b1; wcen = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
